// File: rtl/memif_sdram_pkg.sv
// memif_sdram_pkg: shared constants for the SDRAM client arbiter.
//   - SDRAM_AW        : SDRAM byte address width
//   - ST_*            : arbiter FSM state encodings
//   - W8/W16/W32      : client data width codes (value = width in bits)
//   - ARB_FIXED/ARB_RR: arbitration mode selectors
//   - BASE_*          : SDRAM byte base of each memory region
//   - reloc()         : client address -> SDRAM byte address
package memif_sdram_pkg;

    localparam int SDRAM_AW = 25;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    // Client width codes, as carried in the CH_WIDTH parameter
    localparam logic [7:0] W8  = 8'd8;
    localparam logic [7:0] W16 = 8'd16;
    localparam logic [7:0] W32 = 8'd32;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Region bases, matching the ROM/RAM/SRAM/BMP memory map
    localparam logic [SDRAM_AW-1:0] BASE_ROM  = 25'h000_0000;
    localparam logic [SDRAM_AW-1:0] BASE_RAM  = 25'h080_0000;
    localparam logic [SDRAM_AW-1:0] BASE_SRAM = 25'h100_0000;
    localparam logic [SDRAM_AW-1:0] BASE_BMP  = 25'h180_0000;

    // Relocation wraps modulo 2^SDRAM_AW
    function automatic logic [SDRAM_AW-1:0] reloc(input logic [SDRAM_AW-1:0] base,
                                                  input logic [SDRAM_AW-1:0] addr);
        return base + addr;
    endfunction

endpackage

// File: rtl/memif_sdram_lane.sv
// memif_sdram_lane: combinational byte-lane steering for one client.
//   i_width : client width code (W8/W16/W32)
//   i_lane  : client byte address bits [1:0]
//   i_di    : right-justified client write data
//   i_be    : client byte enables (used by 32-bit clients only)
//   i_dout  : SDRAM read data
//   o_din   : write data replicated onto the addressed lanes
//   o_be    : SDRAM byte enables
//   o_rdata : read data, addressed lane(s) right-justified, zero-extended
module memif_sdram_lane
    import memif_sdram_pkg::*;
(
    input  logic [7:0]  i_width,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_di,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_dout,
    output logic [31:0] o_din,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_din   = i_di;
        o_be    = i_be;
        o_rdata = i_dout;
        case (i_width)
            W8: begin
                o_din   = {4{i_di[7:0]}};
                o_be    = 4'b0001 << i_lane;
                o_rdata = {24'd0, i_dout[{i_lane, 3'b000} +: 8]};
            end
            W16: begin
                o_din   = {2{i_di[15:0]}};
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_rdata = {16'd0, (i_lane[1] ? i_dout[31:16] : i_dout[15:0])};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memif_sdram_arb.sv
// memif_sdram_arb: NCH-channel arbiter in front of the MiSTer SDRAM
// controller strobe/ready port. One operation outstanding at a time.
//   i_sdram_clk / i_sdram_resn : clock, synchronous active-low reset
//   i_ch_req  : per-channel one-cycle request pulse
//   i_ch_we/a/di/be : per-channel op fields, held from REQ until ACK
//   o_ch_do   : data of the last completed read (lane-steered)
//   o_ch_ack  : per-channel one-cycle completion pulse
//   o_busy    : FSM not idle
//   o_sdram_* : controller address/data/BE/strobes
//   i_sdram_rd_rdy / i_sdram_we_rdy / i_sdram_dout : controller side
module memif_sdram_arb
    import memif_sdram_pkg::*;
#(
    parameter int                   NCH      = 4,
    parameter int                   ARB_MODE = ARB_FIXED,
    parameter logic [NCH*8-1:0]     CH_WIDTH = {NCH{8'd32}},
    parameter logic [NCH*25-1:0]    CH_BASE  = {NCH{25'd0}}
) (
    input  logic                    i_sdram_clk,
    input  logic                    i_sdram_resn,
    input  logic [NCH-1:0]          i_ch_req,
    input  logic [NCH-1:0]          i_ch_we,
    input  logic [NCH*25-1:0]       i_ch_a,
    input  logic [NCH*32-1:0]       i_ch_di,
    input  logic [NCH*4-1:0]        i_ch_be,
    output logic [31:0]             o_ch_do,
    output logic [NCH-1:0]          o_ch_ack,
    output logic                    o_busy,
    output logic [SDRAM_AW-1:0]     o_sdram_raddr,
    output logic [SDRAM_AW-1:0]     o_sdram_waddr,
    output logic [31:0]             o_sdram_din,
    output logic [3:0]              o_sdram_be,
    output logic                    o_sdram_rd,
    output logic                    o_sdram_we,
    input  logic                    i_sdram_rd_rdy,
    input  logic                    i_sdram_we_rdy,
    input  logic [31:0]             i_sdram_dout
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]          r_state;
    logic [NCH-1:0]      r_pend;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_gnt;
    logic                r_we;
    logic [SDRAM_AW-1:0] r_addr;
    logic [31:0]         r_din;
    logic [3:0]          r_be;
    logic [31:0]         r_do;

    logic                w_gnt_vld;
    logic [IW-1:0]       w_gnt;
    logic [IW-1:0]       w_sel;
    logic                w_rdy;
    logic                w_issue;
    logic                w_done;
    logic [NCH-1:0]      w_ack;
    logic [31:0]         w_lane_din;
    logic [3:0]          w_lane_be;
    logic [31:0]         w_lane_rdata;
    logic [SDRAM_AW-1:0] w_addr;

    function automatic int rr_idx(input int p, input int k);
        return (p + k >= NCH) ? (p + k - NCH) : (p + k);
    endfunction

    // Descending scan: the last hit (lowest search offset) wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ARB_MODE == ARB_RR) begin
                if (r_pend[rr_idx(int'(r_rr_ptr), k)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = IW'(rr_idx(int'(r_rr_ptr), k));
                end
            end else begin
                if (r_pend[k]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = IW'(k);
                end
            end
        end
    end

    // The single lane steerer looks at the candidate in IDLE (write
    // fields get registered) and at the owner afterwards (read data).
    assign w_sel  = (r_state == ST_IDLE) ? w_gnt : r_gnt;
    assign w_addr = reloc(CH_BASE[int'(w_sel)*25 +: 25], i_ch_a[int'(w_sel)*25 +: 25]);

    memif_sdram_lane u_lane (
        .i_width (CH_WIDTH[int'(w_sel)*8 +: 8]),
        .i_lane  (i_ch_a[int'(w_sel)*25 +: 2]),
        .i_di    (i_ch_di[int'(w_sel)*32 +: 32]),
        .i_be    (i_ch_be[int'(w_sel)*4 +: 4]),
        .i_dout  (i_sdram_dout),
        .o_din   (w_lane_din),
        .o_be    (w_lane_be),
        .o_rdata (w_lane_rdata)
    );

    // Strobe and ACK follow ready combinationally so each lands in the
    // first cycle ready is seen; both are suppressed while in reset.
    assign w_rdy   = r_we ? i_sdram_we_rdy : i_sdram_rd_rdy;
    assign w_issue = i_sdram_resn && (r_state == ST_ISSUE) && w_rdy;
    assign w_done  = i_sdram_resn && (r_state == ST_WAIT) && w_rdy;

    always_comb begin
        for (int i = 0; i < NCH; i++)
            w_ack[i] = w_done && (r_gnt == IW'(i));
    end

    always_ff @(posedge i_sdram_clk) begin
        if (!i_sdram_resn) begin
            r_state  <= ST_IDLE;
            r_pend   <= '0;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_be     <= '0;
            r_do     <= '0;
        end else begin
            // A REQ landing on the ACK cycle re-arms the channel.
            r_pend <= (r_pend & ~w_ack) | i_ch_req;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt    <= w_gnt;
                        r_we     <= i_ch_we[w_gnt];
                        r_addr   <= w_addr;
                        r_din    <= w_lane_din;
                        r_be     <= w_lane_be;
                        r_rr_ptr <= (w_gnt == IW'(NCH - 1)) ? '0 : w_gnt + IW'(1);
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_rdy)
                        r_state <= ST_SETTLE;
                end
                // Controller ready is not yet meaningful for this op.
                ST_SETTLE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_rdy) begin
                        r_state <= ST_IDLE;
                        if (!r_we)
                            r_do <= w_lane_rdata;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ch_do       = r_do;
    assign o_ch_ack      = w_ack;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_sdram_raddr = r_addr;
    assign o_sdram_waddr = r_addr;
    assign o_sdram_din   = r_din;
    assign o_sdram_be    = r_be;
    assign o_sdram_rd    = w_issue && !r_we;
    assign o_sdram_we    = w_issue && r_we;

endmodule

// File: tb/tb_memif_sdram_arb.sv
module tb_memif_sdram_arb;
    localparam int NCH = 4;
    // ch0 8-bit, ch1 16-bit, ch2/ch3 32-bit
    localparam logic [NCH*8-1:0]  P_W    = {8'd32, 8'd32, 8'd16, 8'd8};
    localparam logic [NCH*25-1:0] P_BASE = {25'h1FFFFFF, 25'h0100000, 25'h0, 25'h0};

    logic              clk = 1'b0;
    logic              resn;
    logic [NCH-1:0]    req, we;
    logic [NCH*25-1:0] a;
    logic [NCH*32-1:0] di;
    logic [NCH*4-1:0]  be;
    logic              rd_rdy, we_rdy;
    logic [31:0]       dout;

    logic [31:0]       f_do, r_do;
    logic [NCH-1:0]    f_ack, r_ack;
    logic              f_busy, r_busy, f_rd, r_rd, f_we, r_we;
    logic [24:0]       f_raddr, f_waddr, r_raddr, r_waddr;
    logic [31:0]       f_din, r_din;
    logic [3:0]        f_be, r_be;

    int errors = 0;
    int checks = 0;

    typedef struct { int ch; logic [31:0] exp_do; } exp_t;
    exp_t        q_f[$], q_r[$];
    exp_t        ef, er;
    logic [31:0] m_do_f = 32'd0, m_do_r = 32'd0;
    logic [31:0] exp_do_f, exp_do_r;
    logic        chk_f = 1'b0, chk_r = 1'b0;
    logic [3:0]  m_f, m_r;

    always #5 clk = ~clk;

    memif_sdram_arb #(.NCH(NCH), .ARB_MODE(0), .CH_WIDTH(P_W), .CH_BASE(P_BASE)) u_fix (
        .i_sdram_clk(clk), .i_sdram_resn(resn), .i_ch_req(req), .i_ch_we(we),
        .i_ch_a(a), .i_ch_di(di), .i_ch_be(be), .o_ch_do(f_do), .o_ch_ack(f_ack),
        .o_busy(f_busy), .o_sdram_raddr(f_raddr), .o_sdram_waddr(f_waddr),
        .o_sdram_din(f_din), .o_sdram_be(f_be), .o_sdram_rd(f_rd), .o_sdram_we(f_we),
        .i_sdram_rd_rdy(rd_rdy), .i_sdram_we_rdy(we_rdy), .i_sdram_dout(dout));

    memif_sdram_arb #(.NCH(NCH), .ARB_MODE(1), .CH_WIDTH(P_W), .CH_BASE(P_BASE)) u_rr (
        .i_sdram_clk(clk), .i_sdram_resn(resn), .i_ch_req(req), .i_ch_we(we),
        .i_ch_a(a), .i_ch_di(di), .i_ch_be(be), .o_ch_do(r_do), .o_ch_ack(r_ack),
        .o_busy(r_busy), .o_sdram_raddr(r_raddr), .o_sdram_waddr(r_waddr),
        .o_sdram_din(r_din), .o_sdram_be(r_be), .o_sdram_rd(r_rd), .o_sdram_we(r_we),
        .i_sdram_rd_rdy(rd_rdy), .i_sdram_we_rdy(we_rdy), .i_sdram_dout(dout));

    // Scoreboard: each ACK pops the next expected channel; CH_DO is
    // compared one cycle later, once its register has loaded.
    always @(negedge clk) begin
        if (chk_f) begin
            checks++;
            if (f_do !== exp_do_f) begin errors++; $display("FAIL fix_ch_do got=%h exp=%h", f_do, exp_do_f); end
            chk_f = 1'b0;
        end
        if (chk_r) begin
            checks++;
            if (r_do !== exp_do_r) begin errors++; $display("FAIL rr_ch_do got=%h exp=%h", r_do, exp_do_r); end
            chk_r = 1'b0;
        end
        if (f_ack !== 4'b0000) begin
            checks++;
            if (q_f.size() == 0) begin
                errors++; $display("FAIL fix_ack unexpected got=%b exp=none", f_ack);
            end else begin
                ef = q_f.pop_front();
                m_f = 4'b0001 << ef.ch;
                if (f_ack !== m_f) begin errors++; $display("FAIL fix_ack_order got=%b exp=%b", f_ack, m_f); end
                exp_do_f = ef.exp_do; chk_f = 1'b1;
            end
        end
        if (r_ack !== 4'b0000) begin
            checks++;
            if (q_r.size() == 0) begin
                errors++; $display("FAIL rr_ack unexpected got=%b exp=none", r_ack);
            end else begin
                er = q_r.pop_front();
                m_r = 4'b0001 << er.ch;
                if (r_ack !== m_r) begin errors++; $display("FAIL rr_ack_order got=%b exp=%b", r_ack, m_r); end
                exp_do_r = er.exp_do; chk_r = 1'b1;
            end
        end
    end

    task automatic push_f(input int ch, input logic rd, input logic [31:0] d);
        if (rd) m_do_f = d;
        q_f.push_back('{ch, m_do_f});
    endtask

    task automatic push_r(input int ch, input logic rd, input logic [31:0] d);
        if (rd) m_do_r = d;
        q_r.push_back('{ch, m_do_r});
    endtask

    task automatic push_both(input int ch, input logic rd, input logic [31:0] d);
        push_f(ch, rd, d);
        push_r(ch, rd, d);
    endtask

    task automatic set_ch(input int ch, input logic w, input logic [24:0] ad,
                          input logic [31:0] d, input logic [3:0] b);
        we[ch] = w;
        a[ch*25 +: 25] = ad;
        di[ch*32 +: 32] = d;
        be[ch*4 +: 4] = b;
    endtask

    // Returns just after the edge that starts cycle t+1.
    task automatic pulse(input logic [3:0] m);
        @(posedge clk); #1 req = m;
        @(posedge clk); #1 req = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q_f.size() != 0 || q_r.size() != 0 || chk_f || chk_r) && n < 200) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        checks++;
        if (q_f.size() != 0 || q_r.size() != 0) begin
            errors++;
            $display("FAIL ack_timeout got=pending fix=%0d rr=%0d exp=0", q_f.size(), q_r.size());
            q_f.delete(); q_r.delete();
        end
    endtask

    task automatic test_reset();
        resn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", f_busy); end
        checks++; if (f_ack !== 4'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", f_ack); end
        checks++; if ({f_rd, f_we} !== 2'b00) begin errors++; $display("FAIL rst_strobes got=%b exp=00", {f_rd, f_we}); end
        checks++; if (f_do !== 32'd0) begin errors++; $display("FAIL rst_do got=%h exp=0", f_do); end
        checks++; if ({f_raddr, f_waddr, f_din, f_be} !== '0) begin errors++; $display("FAIL rst_fields got=%h/%h/%h/%h exp=0", f_raddr, f_waddr, f_din, f_be); end
        checks++; if ({r_busy, r_ack, r_rd, r_we} !== '0) begin errors++; $display("FAIL rst_rr got=%b exp=0", {r_busy, r_ack, r_rd, r_we}); end
        @(posedge clk); #1 resn = 1'b1;
    endtask

    task automatic test_read32();
        dout = 32'hDEADBEEF;
        set_ch(2, 1'b0, 25'h10, 32'd0, 4'd0);
        push_both(2, 1'b1, 32'hDEADBEEF);
        pulse(4'b0100);
        @(negedge clk); // t+1
        checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL rd32_idle_busy got=%b exp=0", f_busy); end
        @(negedge clk); // t+2
        checks++; if ({f_rd, f_we, f_busy} !== 3'b101) begin errors++; $display("FAIL rd32_issue got=%b exp=101", {f_rd, f_we, f_busy}); end
        checks++; if (f_raddr !== 25'h0100010) begin errors++; $display("FAIL rd32_raddr got=%h exp=0100010", f_raddr); end
        @(negedge clk); // t+3
        checks++; if (f_rd !== 1'b0) begin errors++; $display("FAIL rd32_one_strobe got=%b exp=0", f_rd); end
        @(negedge clk); // t+4
        checks++; if (f_ack !== 4'b0100) begin errors++; $display("FAIL rd32_ack_latency got=%b exp=0100", f_ack); end
        wait_done();
    endtask

    task automatic test_lane8();
        set_ch(0, 1'b1, 25'h3, 32'h5A, 4'd0);
        push_both(0, 1'b0, 32'd0);
        pulse(4'b0001);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({f_we, f_rd} !== 2'b10) begin errors++; $display("FAIL wr8_strobe got=%b exp=10", {f_we, f_rd}); end
        checks++; if (f_din !== 32'h5A5A5A5A) begin errors++; $display("FAIL wr8_din got=%h exp=5a5a5a5a", f_din); end
        checks++; if (f_be !== 4'b1000) begin errors++; $display("FAIL wr8_be got=%b exp=1000", f_be); end
        checks++; if (f_waddr !== 25'h3) begin errors++; $display("FAIL wr8_waddr got=%h exp=3", f_waddr); end
        wait_done();
        dout = 32'h12345678;
        set_ch(0, 1'b0, 25'h2, 32'd0, 4'd0);
        push_both(0, 1'b1, 32'h00000034);
        pulse(4'b0001);
        wait_done();
    endtask

    task automatic test_lane16();
        set_ch(1, 1'b1, 25'h0, 32'h0000BEEF, 4'd0);
        push_both(1, 1'b0, 32'd0);
        pulse(4'b0010);
        @(negedge clk);
        @(negedge clk);
        checks++; if (f_din !== 32'hBEEFBEEF) begin errors++; $display("FAIL wr16_din got=%h exp=beefbeef", f_din); end
        checks++; if (f_be !== 4'b0011) begin errors++; $display("FAIL wr16_be got=%b exp=0011", f_be); end
        wait_done();
        dout = 32'h12345678;
        set_ch(1, 1'b0, 25'h2, 32'd0, 4'd0);
        push_both(1, 1'b1, 32'h00001234);
        pulse(4'b0010);
        wait_done();
    endtask

    task automatic test_arb_order();
        dout = 32'hCAFEF00D;
        // lone ch1 grant leaves the round-robin pointer at 2
        set_ch(1, 1'b0, 25'h0, 32'd0, 4'd0);
        push_both(1, 1'b1, 32'h0000F00D);
        pulse(4'b0010);
        wait_done();
        set_ch(0, 1'b0, 25'h1, 32'd0, 4'd0);
        set_ch(2, 1'b0, 25'h20, 32'd0, 4'd0);
        set_ch(3, 1'b0, 25'h2, 32'd0, 4'd0);
        push_f(0, 1'b1, 32'h000000F0); push_f(1, 1'b1, 32'h0000F00D);
        push_f(2, 1'b1, 32'hCAFEF00D); push_f(3, 1'b1, 32'hCAFEF00D);
        push_r(2, 1'b1, 32'hCAFEF00D); push_r(3, 1'b1, 32'hCAFEF00D);
        push_r(0, 1'b1, 32'h000000F0); push_r(1, 1'b1, 32'h0000F00D);
        pulse(4'b1111);
        wait_done();
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        we_rdy = 1'b0;
        set_ch(2, 1'b1, 25'h40, 32'h11223344, 4'b0101);
        push_both(2, 1'b0, 32'd0);
        pulse(4'b0100);
        @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            if (f_we !== 1'b0 || f_busy !== 1'b1 || r_we !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
        @(posedge clk); #1 we_rdy = 1'b1;
        @(negedge clk);
        checks++; if (f_we !== 1'b1) begin errors++; $display("FAIL stall_strobe got=%b exp=1", f_we); end
        checks++; if ({f_din, f_be} !== {32'h11223344, 4'b0101}) begin errors++; $display("FAIL wr32_fields got=%h/%b exp=11223344/0101", f_din, f_be); end
        @(negedge clk);
        checks++; if ({f_we, f_ack} !== 5'b0) begin errors++; $display("FAIL stall_settle got=%b exp=0", {f_we, f_ack}); end
        wait_done();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        dout = 32'h0F0F1234;
        set_ch(1, 1'b0, 25'h4, 32'd0, 4'd0);
        pulse(4'b0010);
        @(negedge clk);
        @(negedge clk);                       // ISSUE with ready high
        @(posedge clk); #1 rd_rdy = 1'b0;     // SETTLE
        @(posedge clk); #1 req = 4'b0001;     // WAIT; ch0 becomes pending
        set_ch(0, 1'b0, 25'h0, 32'd0, 4'd0);
        @(posedge clk); #1 req = '0; resn = 1'b0;
        @(negedge clk);
        checks++; if ({f_ack, r_ack} !== 8'd0) begin errors++; $display("FAIL rstmid_ack got=%b exp=0", {f_ack, r_ack}); end
        @(posedge clk); #1 resn = 1'b1;
        m_do_f = 32'd0; m_do_r = 32'd0;
        @(negedge clk);
        checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", f_busy); end
        checks++; if (f_do !== 32'd0) begin errors++; $display("FAIL rstmid_do got=%h exp=0", f_do); end
        @(posedge clk); #1 rd_rdy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (f_busy !== 1'b0 || r_busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_pend_cleared got=%0d busy cycles exp=0", bad); end
        push_both(1, 1'b1, 32'h00001234);
        pulse(4'b0010);
        wait_done();
    endtask

    task automatic test_dup_wrap();
        dout = 32'h0BADF00D;
        set_ch(3, 1'b0, 25'h2, 32'd0, 4'd0);
        push_both(3, 1'b1, 32'h0BADF00D);
        pulse(4'b1000);
        req = 4'b1000;                        // duplicate while pending
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        checks++; if ({f_rd, f_raddr} !== {1'b1, 25'h0000001}) begin errors++; $display("FAIL wrap_raddr got=%b/%h exp=1/0000001", f_rd, f_raddr); end
        wait_done();
        repeat (8) @(negedge clk);
        checks++; if ({f_busy, r_busy} !== 2'b00) begin errors++; $display("FAIL dup_busy got=%b exp=00", {f_busy, r_busy}); end
    endtask

    initial begin
        resn = 1'b0; req = '0; we = '0; a = '0; di = '0; be = '0;
        rd_rdy = 1'b1; we_rdy = 1'b1; dout = '0;
        test_reset();
        test_read32();
        test_lane8();
        test_lane16();
        test_arb_order();
        test_stall();
        test_reset_mid();
        test_dup_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/memif_sdram_arb.md
Name: memif_sdram_arb

Overview:
- N-channel arbiter between independent memory clients (ROM, RAM, SRAM, BMP, future DMA) and the MiSTer SDRAM controller's read/write strobe-and-ready port.
- Per channel: request latching, base-address relocation, byte-lane steering for 8/16/32-bit clients, and a one-cycle acknowledge.
- Arbitration is fixed priority or round robin.
- Only one SDRAM operation is outstanding at a time.

Parameters:
- NCH, 4, number of client channels (1..8).
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round robin.
- CH_WIDTH, {NCH{8'd32}}, packed NCH x 8 bits: client data width per channel, 8/16/32.
- CH_BASE, {NCH{25'd0}}, packed NCH x 25 bits: SDRAM byte base address per channel.

Ports:
- SDRAM_CLK  in  1  sole clock.
- SDRAM_RESn  in  1  reset; synchronous, active-low.
- CH_REQ  in  NCH  one-cycle request pulse per channel.
- CH_WE  in  NCH  1 = write, 0 = read; held stable from REQ until ACK.
- CH_A  in  NCH*25  byte address per channel; held stable.
- CH_DI  in  NCH*32  write data, right-justified; held stable.
- CH_BE  in  NCH*4  byte enables, used for 32-bit channels only.
- CH_DO  out  32  read data of the last completed read, right-justified.
- CH_ACK  out  NCH  one-cycle completion pulse.
- BUSY  out  1  state is not IDLE.
- SDRAM_RADDR / SDRAM_WADDR  out  25  operation address.
- SDRAM_DIN  out  32  write data.
- SDRAM_BE  out  4  write byte enables.
- SDRAM_RD / SDRAM_WE  out  1  operation strobes.
- SDRAM_RD_RDY / SDRAM_WE_RDY  in  1  controller ready.
- SDRAM_DOUT  in  32  read data.

Behaviour:
- Reset values: state IDLE; pend = 0; rr_ptr = 0; CH_ACK = 0; SDRAM_RD = 0; SDRAM_WE = 0; CH_DO = 0; BUSY = 0; address/data/BE outputs = 0.
- Request latching: pend[i] sets on CH_REQ[i] and clears in the cycle CH_ACK[i] pulses.
- A REQ on a channel whose pend bit is already set is ignored; there is no queueing and no error flag.
- A REQ arriving in the same cycle as that channel's ACK sets pend again.
- IDLE: if pend is nonzero, grant one channel g and register the operation fields, then go to ISSUE. A REQ is eligible for grant in the cycle after its pulse.
  - Registered fields: addr = CH_BASE[g] + CH_A[g] (25-bit add, overflow wraps mod 2^25), we, and the lane-steered DIN/BE.
- ISSUE: for a read, assert SDRAM_RD for exactly one cycle in the first cycle SDRAM_RD_RDY = 1. Writes behave the same using SDRAM_WE / SDRAM_WE_RDY. Then go to SETTLE. A ready that stays low stalls ISSUE indefinitely.
- SETTLE: one dead cycle; the controller's ready is ignored here. Then go to WAIT.
- WAIT: on the first cycle the matching ready = 1, pulse CH_ACK[g], return to IDLE, and for reads register CH_DO from SDRAM_DOUT. CH_DO holds until the next read completes; writes leave it unchanged.
- Minimum latency: REQ at cycle t, ACK at cycle t+4 (IDLE t+1, ISSUE t+2, SETTLE t+3, WAIT t+4), given ready = 1 throughout.
- Back-to-back grant: the next grant occurs in the IDLE cycle following ACK.
- Fixed priority: the lowest-index pend bit wins.
- Round robin: search starts at rr_ptr and wraps at NCH-1 to 0. On grant, rr_ptr <= (g+1) mod NCH.
- Lane steering, 8-bit channels: lane = A[1:0]; DIN = {4{DI[7:0]}}; BE = one-hot of the lane; CH_DO = DOUT byte lane, zero-extended.
- Lane steering, 16-bit channels: lane = A[1]; DIN = {2{DI[15:0]}}; BE = 0011 or 1100; CH_DO = selected halfword, zero-extended.
- Lane steering, 32-bit channels: DIN = DI; BE = CH_BE; CH_DO = DOUT.
- Address: SDRAM_RADDR and SDRAM_WADDR both carry the full byte address, including the low bits.
- The controller ignores SDRAM_DIN and SDRAM_BE on reads.
- Reset mid-operation: return to IDLE and clear all pend bits with no ACK. A still-running SDRAM operation finishes unobserved; its data is discarded. The next grant still waits for ready in ISSUE.

Decomposition:
- Package memif_sdram_pkg:
  - state enum {IDLE, ISSUE, SETTLE, WAIT};
  - width codes W8/W16/W32;
  - SDRAM_AW = 25;
  - ARB_FIXED / ARB_RR constants;
  - per-region base constants, shared with the existing ROM/RAM/SRAM/BMP memory map.
- Sub-module memif_sdram_lane: combinational lane steering of DI/BE for writes and DOUT for reads, instantiated once on the granted channel's fields.

Test Plan:
- NCH=4 fixed priority; ch2 32-bit read at A=0x10, CH_BASE[2]=0x100000, ready = 1, DOUT=0xDEADBEEF -> SDRAM_RADDR=0x100010, one-cycle SDRAM_RD, CH_ACK[2] at t+4, CH_DO=0xDEADBEEF.
- ch0 8-bit write DI=0x5A at A=0x3 -> SDRAM_DIN=0x5A5A5A5A, SDRAM_BE=1000, SDRAM_WE pulse, ACK[0]; a following read with DOUT=0x12345678 at A=0x2 -> CH_DO=0x00000034.
- Simultaneous REQ on ch0..ch3: fixed priority -> ACK order 0,1,2,3; round robin with rr_ptr=2 -> ACK order 2,3,0,1.
- SDRAM_WE_RDY held low 10 cycles during ISSUE -> no strobe, BUSY=1; strobe in the first cycle ready=1; ACK two cycles later or later.
- SDRAM_RESn asserted during WAIT with ch1 pending -> no ACK, pend = 0, BUSY=0 next cycle; a new REQ is serviced normally.
- Duplicate REQ on ch3 while pending; address wrap with CH_BASE=0x1FFFFFF, A=2 -> exactly one ACK; SDRAM_RADDR=0x0000001.
